// File: rtl/package_settings.sv
// Shared settings for the filter chain and its downstream peak finders.
package package_settings;

  localparam int unsigned SIZE_FILTER_DATA = 16;
  localparam int unsigned SIZE_TIMESTAMP   = 16;
  localparam int unsigned PEAK_DEAD_TIME   = 8;
  localparam int unsigned PEAK_MAX_WIDTH   = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    DEAD     = 2'd2,
    WAIT_LOW = 2'd3
  } peak_state_t;

  // Record layout for consumers that pack the default-width outputs into one word.
  typedef struct packed {
    logic signed [SIZE_FILTER_DATA-1:0] amplitude;
    logic [SIZE_TIMESTAMP-1:0]          timestamp;
    logic                               pileup;
  } peak_record_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/peak_finder.sv
// Threshold-triggered peak detector: reports peak amplitude and timestamp per pulse,
// flags over-long pulses as pile-up and holds off re-arming for a dead time.
module peak_finder
  import package_settings::*;
#(
  parameter int unsigned DATA_W    = SIZE_FILTER_DATA,
  parameter int unsigned TIME_W    = SIZE_TIMESTAMP,
  parameter int unsigned DEAD_TIME = PEAK_DEAD_TIME,
  parameter int unsigned MAX_WIDTH = PEAK_MAX_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] input_data,
  input  logic signed [DATA_W-1:0] threshold,
  output logic signed [DATA_W-1:0] output_amplitude,
  output logic [TIME_W-1:0]        output_time,
  output logic                     output_pileup,
  output logic                     output_valid,
  output logic [15:0]              output_count,
  output logic                     busy
);

  localparam int unsigned WidthW = (MAX_WIDTH > 2) ? $clog2(MAX_WIDTH) : 1;
  localparam int unsigned DeadW  = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
  // width_q counts samples already in the pulse, so the current one is width_q + 1.
  localparam logic [WidthW-1:0] WidthLast = WidthW'(MAX_WIDTH - 1);
  localparam logic [DeadW-1:0]  DeadLoad  = DeadW'(DEAD_TIME - 1);

  logic [TIME_W-1:0]        ts_q;
  logic signed [DATA_W-1:0] s_q;
  logic [TIME_W-1:0]        s_time;

  peak_state_t              state_q, state_d;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic [TIME_W-1:0]        max_time_q, max_time_d;
  logic [WidthW-1:0]        width_q, width_d;
  logic [DeadW-1:0]         dead_q, dead_d;

  logic                     above;
  logic                     emit;
  logic                     emit_pileup;

  logic signed [DATA_W-1:0] amp_q;
  logic [TIME_W-1:0]        time_q;
  logic                     pileup_q;
  logic                     valid_q;
  logic [15:0]              count_q;

  // s_q was captured one edge ago, when the counter was one lower than now.
  assign s_time = ts_q - TIME_W'(1);
  assign above  = (s_q > threshold);

  always_comb begin
    state_d     = state_q;
    max_d       = max_q;
    max_time_d  = max_time_q;
    width_d     = width_q;
    dead_d      = dead_q;
    emit        = 1'b0;
    emit_pileup = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (above) begin
          state_d    = ARMED;
          max_d      = s_q;
          max_time_d = s_time;
          width_d    = WidthW'(1);
        end
      end
      ARMED: begin
        // Strict compare keeps the first of equal peaks.
        if (s_q > max_q) begin
          max_d      = s_q;
          max_time_d = s_time;
        end
        width_d = width_q + WidthW'(1);
        if (!above) begin
          emit    = 1'b1;
          state_d = DEAD;
          dead_d  = DeadLoad;
        end else if (width_q == WidthLast) begin
          emit        = 1'b1;
          emit_pileup = 1'b1;
          state_d     = DEAD;
          dead_d      = DeadLoad;
        end
      end
      DEAD: begin
        if (dead_q == '0) begin
          state_d = above ? WAIT_LOW : IDLE;
        end else begin
          dead_d = dead_q - DeadW'(1);
        end
      end
      WAIT_LOW: begin
        if (!above) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q       <= '0;
      s_q        <= '0;
      state_q    <= IDLE;
      max_q      <= '0;
      max_time_q <= '0;
      width_q    <= '0;
      dead_q     <= '0;
      amp_q      <= '0;
      time_q     <= '0;
      pileup_q   <= 1'b0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      ts_q       <= ts_q + TIME_W'(1);
      s_q        <= input_data;
      state_q    <= state_d;
      max_q      <= max_d;
      max_time_q <= max_time_d;
      width_q    <= width_d;
      dead_q     <= dead_d;
      valid_q    <= emit;
      if (emit) begin
        amp_q    <= max_d;
        time_q   <= max_time_d;
        pileup_q <= emit_pileup;
        count_q  <= sat_inc16(count_q);
      end
    end
  end

  assign output_amplitude = amp_q;
  assign output_time      = time_q;
  assign output_pileup    = pileup_q;
  assign output_valid     = valid_q;
  assign output_count     = count_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_peak_finder.sv
// Scoreboard bench for peak_finder: expected records are queued as pulses are driven
// and compared whenever output_valid is seen.
module tb_peak_finder;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned TIME_W    = 16;
  localparam int unsigned DEAD_TIME = 4;
  localparam int unsigned MAX_WIDTH = 64;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic signed [DATA_W-1:0] input_data = '0;
  logic signed [DATA_W-1:0] threshold = 16'sd100;
  logic signed [DATA_W-1:0] output_amplitude;
  logic [TIME_W-1:0]        output_time;
  logic                     output_pileup;
  logic                     output_valid;
  logic [15:0]              output_count;
  logic                     busy;

  typedef struct {
    logic [15:0] amp;
    logic [15:0] tim;
    logic        pile;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] tb_ts;
  logic [15:0] pk;

  always #5 clk = ~clk;

  peak_finder #(
    .DATA_W   (DATA_W),
    .TIME_W   (TIME_W),
    .DEAD_TIME(DEAD_TIME),
    .MAX_WIDTH(MAX_WIDTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .input_data      (input_data),
    .threshold       (threshold),
    .output_amplitude(output_amplitude),
    .output_time     (output_time),
    .output_pileup   (output_pileup),
    .output_valid    (output_valid),
    .output_count    (output_count),
    .busy            (busy)
  );

  // Timestamp the currently driven sample will receive when captured.
  always @(posedge clk) begin
    if (reset) tb_ts <= '0;
    else       tb_ts <= tb_ts + 16'd1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (output_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("valid_unexpected", 32'(output_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("rec_amplitude", 32'(output_amplitude), 32'(e.amp));
        check_eq("rec_time", 32'(output_time), 32'(e.tim));
        check_eq("rec_pileup", 32'(output_pileup), 32'(e.pile));
        check_eq("rec_count", 32'(output_count), 32'(e.cnt));
      end
    end
  end

  task automatic drive(input int v);
    input_data = 16'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_until(input logic [15:0] t);
    while (tb_ts != t) drive(0);
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_valid"}, 32'(output_valid), 32'd0);
    check_eq({tag, "_amplitude"}, 32'(output_amplitude), 32'd0);
    check_eq({tag, "_time"}, 32'(output_time), 32'd0);
    check_eq({tag, "_pileup"}, 32'(output_pileup), 32'd0);
    check_eq({tag, "_count"}, 32'(output_count), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  int tri_s[7]    = '{0, 50, 150, 300, 220, 90, 0};
  int eq_s[4]     = '{120, 250, 250, 80};
  int dead_a[11]  = '{150, 300, 150, 50, 50, 50, 50, 200, 400, 200, 50};
  int dead_b[15]  = '{150, 300, 150, 50, 50, 50, 50, 50, 50, 50, 50, 200, 400, 200, 50};

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_cleared("reset");
    reset = 1'b0;

    // Triangle pulse at ts 0..6
    sb.push_back('{16'd300, 16'd3, 1'b0, 16'd1});
    foreach (tri_s[i]) drive(tri_s[i]);

    // Equal peaks at ts 10..13
    idle_until(16'd10);
    sb.push_back('{16'd250, 16'd11, 1'b0, 16'd2});
    foreach (eq_s[i]) drive(eq_s[i]);

    // Plateau from ts 20: pile-up after 64 samples, then WAIT_LOW until it drops
    idle_until(16'd20);
    sb.push_back('{16'd200, 16'd20, 1'b1, 16'd3});
    repeat (100) drive(200);
    check_eq("plateau_busy", 32'(busy), 32'd1);
    drive(100);
    repeat (10) drive(0);
    check_eq("plateau_idle", 32'(busy), 32'd0);
    check_eq("hold_amplitude", 32'(output_amplitude), 32'd200);
    check_eq("hold_pileup", 32'(output_pileup), 32'd1);
    check_eq("hold_count", 32'(output_count), 32'd3);

    // Equality with threshold and negative samples never trigger
    for (int i = 0; i < 8; i++) begin
      drive((i < 4) ? 100 : -500);
      check_eq("thr_busy", 32'(busy), 32'd0);
    end
    repeat (2) drive(0);
    check_eq("thr_busy_tail", 32'(busy), 32'd0);
    check_eq("thr_count", 32'(output_count), 32'd3);

    // Second pulse crosses 2 cycles after the first record: ignored
    for (int i = 0; i < 11; i++) begin
      if (i == 1) begin
        pk = tb_ts;
        sb.push_back('{16'd300, pk, 1'b0, 16'd4});
      end
      drive(dead_a[i]);
      if (i == 9) check_eq("dead_busy", 32'(busy), 32'd1);
    end
    repeat (10) drive(0);
    check_eq("dead_count", 32'(output_count), 32'd4);

    // Gap of 6 cycles: second pulse is recorded
    for (int i = 0; i < 15; i++) begin
      if (i == 1 || i == 12) begin
        pk = tb_ts;
        if (i == 1) sb.push_back('{16'd300, pk, 1'b0, 16'd5});
        else        sb.push_back('{16'd400, pk, 1'b0, 16'd6});
      end
      drive(dead_b[i]);
    end
    repeat (10) drive(0);
    check_eq("gap_amplitude", 32'(output_amplitude), 32'd400);
    check_eq("gap_count", 32'(output_count), 32'd6);

    // Reset while ARMED with max 250 discards the pulse
    drive(150);
    drive(250);
    drive(250);
    check_eq("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_cleared("midreset");
    reset = 1'b0;
    drive(0);
    drive(0);
    sb.push_back('{16'd300, 16'd2, 1'b0, 16'd1});
    drive(300);
    drive(50);
    repeat (8) drive(0);

    // Peak lands just after the timestamp wraps
    idle_until(16'hFFFE);
    sb.push_back('{16'd300, 16'd1, 1'b0, 16'd2});
    drive(150);
    drive(250);
    drive(260);
    drive(300);
    drive(50);
    repeat (8) drive(0);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    check_eq("final_count", 32'(output_count), 32'd2);
    check_eq("final_busy", 32'(busy), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
